// File: rtl/alu_word_sequencer_pkg.sv
// Shared op codes, sequencer state encodings and helpers for alu_word_sequencer.
// Optional decimal support is enabled by defining ALU_SEQ_DECIMAL_EN.
package alu_word_sequencer_pkg;

   localparam logic [2:0] kALU_ORA  = 3'd0;
   localparam logic [2:0] kALU_AND  = 3'd1;
   localparam logic [2:0] kALU_EOR  = 3'd2;
   localparam logic [2:0] kALU_ADC  = 3'd3;
   localparam logic [2:0] kALU_SHL  = 3'd4;
   localparam logic [2:0] kALU_SHR  = 3'd5;
   localparam logic [2:0] kALU_ASR  = 3'd6;
   localparam logic [2:0] kALU_ORA2 = 3'd7;

   localparam logic [1:0] kSEQ_IDLE = 2'd0;
   localparam logic [1:0] kSEQ_P1   = 2'd1;
   localparam logic [1:0] kSEQ_P2   = 2'd2;
   localparam logic [1:0] kSEQ_DONE = 2'd3;

   // Right shifts must process the high byte first so its low bit can feed the low byte.
   function automatic logic isRightShift(input logic [2:0] op);
      return (op == kALU_SHR) || (op == kALU_ASR);
   endfunction

endpackage

// File: rtl/alu_word_sequencer_alu_unit.sv
// alu_unit: 8-bit combinational ALU with logic ops, shifts and binary/BCD add.
module alu_unit
   import alu_word_sequencer_pkg::*;
(
   input  logic [2:0] op_i,
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   input  logic       c_i,
   input  logic       dec_add_i,
   input  logic       dec_sub_i,
   output logic [7:0] y_o,
   output logic       c_o,
   output logic       v_o
);

   logic [8:0] sum;
   logic [4:0] lo;
   logic [4:0] hi;
   logic       loCarry;

   assign sum = {1'b0, a_i} + {1'b0, b_i} + {8'd0, c_i};

   // Logic ops report the adder carry, matching the original datapath's default.
   always_comb begin
      y_o     = sum[7:0];
      c_o     = sum[8];
      v_o     = (a_i[7] == b_i[7]) && (sum[7] != a_i[7]);
      lo      = {1'b0, a_i[3:0]} + {1'b0, b_i[3:0]} + {4'd0, c_i};
      hi      = 5'd0;
      loCarry = 1'b0;
      case (op_i)
         kALU_ORA, kALU_ORA2: y_o = a_i | b_i;
         kALU_AND:            y_o = a_i & b_i;
         kALU_EOR:            y_o = a_i ^ b_i;
         kALU_ADC: begin
            if (dec_add_i) begin
               if (lo > 5'd9) lo = lo + 5'd6;
               hi = {1'b0, a_i[7:4]} + {1'b0, b_i[7:4]} + {4'd0, lo[4]};
               if (hi > 5'd9) hi = hi + 5'd6;
               y_o = {hi[3:0], lo[3:0]};
               c_o = hi[4];
            end else if (dec_sub_i) begin
               loCarry = lo[4];
               if (!loCarry) lo = lo - 5'd6;
               hi = {1'b0, a_i[7:4]} + {1'b0, b_i[7:4]} + {4'd0, loCarry};
               c_o = hi[4];
               if (!hi[4]) hi = hi - 5'd6;
               y_o = {hi[3:0], lo[3:0]};
            end
         end
         kALU_SHL: begin
            y_o = {a_i[6:0], c_i};
            c_o = a_i[7];
            v_o = 1'b0;
         end
         kALU_SHR: begin
            y_o = {c_i, a_i[7:1]};
            c_o = a_i[0];
            v_o = 1'b0;
         end
         kALU_ASR: begin
            y_o = {a_i[7], a_i[7:1]};
            c_o = a_i[0];
            v_o = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_word_sequencer.sv
// alu_word_sequencer: runs 8/16-bit ALU ops as byte passes through one alu_unit.
// Define ALU_SEQ_DECIMAL_EN to honour req_dec (BCD add/subtract).
module alu_word_sequencer
   import alu_word_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic        req_word,
   input  logic [15:0] req_a,
   input  logic [15:0] req_b,
   input  logic        req_c,
   input  logic        req_sub,
   input  logic        req_dec,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_y,
   output logic        rsp_n,
   output logic        rsp_z,
   output logic        rsp_c,
   output logic        rsp_v
);

   logic [1:0]  state_q, state_d;
   logic [2:0]  op_q;
   logic        word_q, c_q, sub_q;
   logic [15:0] a_q, b_q;
   logic [7:0]  first_q;
   logic        carry_q;
   logic [15:0] y_q;
   logic        n_q, z_q, cf_q, v_q;

   logic        accept, hiFirst, passHi, lastPass;
   logic [7:0]  aByte, bRaw, bByte, aluY;
   logic [2:0]  aluOp;
   logic        aluC, aluCOut, aluV, decAdd, decSub;
   logic [15:0] resWord;

   assign accept    = req_valid & req_ready;
   assign req_ready = (state_q == kSEQ_IDLE);
   assign rsp_valid = (state_q == kSEQ_DONE);
   assign rsp_y     = y_q;
   assign rsp_n     = n_q;
   assign rsp_z     = z_q;
   assign rsp_c     = cf_q;
   assign rsp_v     = v_q;

`ifdef ALU_SEQ_DECIMAL_EN
   logic dec_q;
   always_ff @(posedge clk) begin
      if (reset)       dec_q <= 1'b0;
      else if (accept) dec_q <= req_dec;
   end
   assign decAdd = dec_q & ~sub_q;
   assign decSub = dec_q & sub_q;
`else
   logic unusedDec;
   assign unusedDec = req_dec;
   assign decAdd    = 1'b0;
   assign decSub    = 1'b0;
`endif

   // Byte-select mux: right-shift words go high byte first, with the low pass forced to SHR.
   assign hiFirst  = word_q & isRightShift(op_q);
   assign passHi   = (state_q == kSEQ_P1) ? hiFirst : ~hiFirst;
   assign aByte    = passHi ? a_q[15:8] : a_q[7:0];
   assign bRaw     = passHi ? b_q[15:8] : b_q[7:0];
   assign bByte    = (sub_q && op_q == kALU_ADC) ? ~bRaw : bRaw;
   assign aluOp    = (state_q == kSEQ_P2 && hiFirst) ? kALU_SHR : op_q;
   assign aluC     = (state_q == kSEQ_P1) ? c_q : carry_q;
   assign lastPass = (state_q == kSEQ_P2) || (state_q == kSEQ_P1 && !word_q);
   assign resWord  = !word_q ? {8'h00, aluY} : (hiFirst ? {first_q, aluY} : {aluY, first_q});

   alu_unit uAlu (
      .op_i      (aluOp),
      .a_i       (aByte),
      .b_i       (bByte),
      .c_i       (aluC),
      .dec_add_i (decAdd),
      .dec_sub_i (decSub),
      .y_o       (aluY),
      .c_o       (aluCOut),
      .v_o       (aluV)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         kSEQ_IDLE: if (req_valid) state_d = kSEQ_P1;
         kSEQ_P1:   state_d = word_q ? kSEQ_P2 : kSEQ_DONE;
         kSEQ_P2:   state_d = kSEQ_DONE;
         kSEQ_DONE: if (rsp_ready) state_d = kSEQ_IDLE;
         default:   state_d = kSEQ_IDLE;
      endcase
   end

   // Response registers only change on the final pass, so DONE holds them stable.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= kSEQ_IDLE;
         op_q    <= kALU_ORA;
         word_q  <= 1'b0;
         a_q     <= 16'h0000;
         b_q     <= 16'h0000;
         c_q     <= 1'b0;
         sub_q   <= 1'b0;
         first_q <= 8'h00;
         carry_q <= 1'b0;
         y_q     <= 16'h0000;
         n_q     <= 1'b0;
         z_q     <= 1'b0;
         cf_q    <= 1'b0;
         v_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q   <= req_op;
            word_q <= req_word;
            a_q    <= req_a;
            b_q    <= req_b;
            c_q    <= req_c;
            sub_q  <= req_sub;
         end
         if (state_q == kSEQ_P1 || state_q == kSEQ_P2) begin
            first_q <= aluY;
            carry_q <= aluCOut;
         end
         if (lastPass) begin
            y_q  <= resWord;
            n_q  <= word_q ? resWord[15] : resWord[7];
            z_q  <= (resWord == 16'h0000);
            cf_q <= aluCOut;
            v_q  <= (op_q == kALU_ADC) ? aluV : 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Directed self-checking bench for alu_word_sequencer (expects decimal results only
// when ALU_SEQ_DECIMAL_EN is defined).
module tb_alu_word_sequencer;
   import alu_word_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = kALU_ORA;
   logic        req_word = 1'b0;
   logic [15:0] req_a = 16'h0000;
   logic [15:0] req_b = 16'h0000;
   logic        req_c = 1'b0;
   logic        req_sub = 1'b0;
   logic        req_dec = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [15:0] rsp_y;
   logic        rsp_n, rsp_z, rsp_c, rsp_v;

   int assertCount = 0;
   int failCount = 0;

   always #5 clk = ~clk;

   alu_word_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_word  (req_word),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_c     (req_c),
      .req_sub   (req_sub),
      .req_dec   (req_dec),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_y     (rsp_y),
      .rsp_n     (rsp_n),
      .rsp_z     (rsp_z),
      .rsp_c     (rsp_c),
      .rsp_v     (rsp_v)
   );

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
      end
   endtask

   // Presents one request on a falling edge, returns #1 after the accepting edge.
   task automatic applyStimulus(input logic [2:0] op, input logic word, input logic [15:0] a,
                                input logic [15:0] b, input logic c, input logic sub, input logic dec);
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_word  = word;
      req_a     = a;
      req_b     = b;
      req_c     = c;
      req_sub   = sub;
      req_dec   = dec;
      checkOutput("req_ready_before_accept", {15'd0, req_ready}, 16'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_a     = 16'hDEAD;
      req_b     = 16'hBEEF;
      req_c     = ~c;
      req_op    = kALU_EOR;
   endtask

   // Waits (bounded) for rsp_valid, then checks latency, result and NZCV.
   task automatic waitResult(input string tag, input int expLat, input logic [15:0] expY,
                             input logic [3:0] expNzcv);
      int n = 1;
      while (!rsp_valid && n < 12) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput({tag, "_latency"}, 16'(n), 16'(expLat));
      checkOutput({tag, "_y"}, rsp_y, expY);
      checkOutput({tag, "_nzcv"}, {12'd0, rsp_n, rsp_z, rsp_c, rsp_v}, {12'd0, expNzcv});
      checkOutput({tag, "_ready_busy"}, {15'd0, req_ready}, 16'd0);
   endtask

   task automatic finishResponse(input string tag);
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      checkOutput({tag, "_valid_cleared"}, {15'd0, rsp_valid}, 16'd0);
      checkOutput({tag, "_ready_back"}, {15'd0, req_ready}, 16'd1);
   endtask

   initial begin
      logic [15:0] decExp;
`ifdef ALU_SEQ_DECIMAL_EN
      decExp = 16'h1000;
`else
      decExp = 16'h099A;
`endif
      $display("[TB] start");
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_req_ready", {15'd0, req_ready}, 16'd1);
      checkOutput("reset_rsp_valid", {15'd0, rsp_valid}, 16'd0);
      checkOutput("reset_rsp_y", rsp_y, 16'h0000);
      checkOutput("reset_flags", {12'd0, rsp_n, rsp_z, rsp_c, rsp_v}, 16'd0);
      @(negedge clk);
      reset = 1'b0;

      applyStimulus(kALU_ADC, 1'b1, 16'h12FF, 16'h0001, 1'b0, 1'b0, 1'b0);
      waitResult("word_adc", 3, 16'h1300, 4'b0000);
      finishResponse("word_adc");

      applyStimulus(kALU_SHR, 1'b1, 16'h8001, 16'h0000, 1'b0, 1'b0, 1'b0);
      waitResult("word_shr", 3, 16'h4000, 4'b0010);
      finishResponse("word_shr");

      applyStimulus(kALU_SHL, 1'b1, 16'h8001, 16'h0000, 1'b1, 1'b0, 1'b0);
      waitResult("word_shl", 3, 16'h0003, 4'b0010);
      finishResponse("word_shl");

      applyStimulus(kALU_AND, 1'b1, 16'h0100, 16'h00FF, 1'b0, 1'b0, 1'b0);
      waitResult("word_and", 3, 16'h0000, 4'b0100);
      finishResponse("word_and");

      applyStimulus(kALU_ADC, 1'b0, 16'hAB7F, 16'hCD01, 1'b0, 1'b0, 1'b0);
      waitResult("byte_adc", 2, 16'h0080, 4'b1001);
      finishResponse("byte_adc");

      applyStimulus(kALU_ADC, 1'b1, 16'h0999, 16'h0001, 1'b0, 1'b0, 1'b1);
      waitResult("word_dec_adc", 3, decExp, 4'b0000);
      finishResponse("word_dec_adc");

      applyStimulus(kALU_ASR, 1'b1, 16'h8001, 16'h0000, 1'b0, 1'b0, 1'b0);
      waitResult("word_asr", 3, 16'hC000, 4'b1010);
      finishResponse("word_asr");

      applyStimulus(kALU_ADC, 1'b1, 16'h1000, 16'h0001, 1'b1, 1'b1, 1'b0);
      waitResult("word_sbc", 3, 16'h0FFF, 4'b0010);
      finishResponse("word_sbc");

      // Backpressure: response must hold while a competing request is ignored.
      applyStimulus(kALU_EOR, 1'b0, 16'h00A5, 16'h000F, 1'b0, 1'b0, 1'b0);
      waitResult("bp_eor", 2, 16'h00AA, 4'b1000);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         req_valid = 1'b1;
         req_op    = kALU_ADC;
         req_word  = 1'b1;
         req_a     = 16'h1111;
         req_b     = 16'h2222;
         @(posedge clk);
         #1;
         checkOutput("bp_hold_y", rsp_y, 16'h00AA);
         checkOutput("bp_hold_nzcv", {12'd0, rsp_n, rsp_z, rsp_c, rsp_v}, 16'b1000);
         checkOutput("bp_hold_valid", {15'd0, rsp_valid}, 16'd1);
         checkOutput("bp_hold_ready", {15'd0, req_ready}, 16'd0);
      end
      @(negedge clk);
      req_valid = 1'b0;
      finishResponse("bp_eor");
      applyStimulus(kALU_ORA2, 1'b0, 16'h000F, 16'h00F0, 1'b1, 1'b0, 1'b0);
      waitResult("bp_next_ora2", 2, 16'h00FF, 4'b1010);
      finishResponse("bp_next_ora2");

      // Reset during P2 aborts the operation without a response.
      applyStimulus(kALU_ADC, 1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("abort_in_p2_valid", {15'd0, rsp_valid}, 16'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("abort_ready", {15'd0, req_ready}, 16'd1);
      checkOutput("abort_valid", {15'd0, rsp_valid}, 16'd0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         checkOutput("abort_no_rsp", {15'd0, rsp_valid}, 16'd0);
      end
      applyStimulus(kALU_SHL, 1'b0, 16'h0081, 16'h0000, 1'b0, 1'b0, 1'b0);
      waitResult("after_abort_shl", 2, 16'h0002, 4'b0010);
      finishResponse("after_abort_shl");
      applyStimulus(kALU_ASR, 1'b0, 16'h0081, 16'h0000, 1'b0, 1'b0, 1'b0);
      waitResult("byte_asr", 2, 16'h00C0, 4'b1010);
      finishResponse("byte_asr");

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
